// File: rtl/acl_ingress_filter.sv
// Ingress filter in front of the ACL receive FIFO: forwards each accepted byte one cycle later,
// parses Ethernet/IPv4 header fields and flags frames that must be dropped on their last beat.
module acl_ingress_filter #(
    parameter int unsigned NUM_RULES   = 4,
    parameter int unsigned MAX_LEN     = 1518,
    parameter int unsigned DROP_NON_IP = 1,
    localparam int unsigned IDX_W      = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       i_rxd_tdata,
    input  logic             i_rxd_tvalid,
    input  logic             i_rx_tlast,
    output logic             o_rxd_tready,
    output logic [7:0]       o_fifo_tdata,
    output logic             o_fifo_tvalid,
    output logic             o_fifo_tlast,
    output logic             o_fifo_invalid,
    input  logic             i_fifo_full,
    input  logic             i_rule_wr_en,
    input  logic [IDX_W-1:0] i_rule_idx,
    input  logic [31:0]      i_rule_ip,
    input  logic             i_rule_en,
    output logic [15:0]      o_pass_cnt,
    output logic [15:0]      o_drop_cnt
);

    localparam int unsigned IX_W = 11;
    localparam logic [IX_W-1:0] LAST_IX    = IX_W'(MAX_LEN - 1);
    localparam logic [IX_W-1:0] ETH_HI_IX  = IX_W'(12);
    localparam logic [IX_W-1:0] ETH_LO_IX  = IX_W'(13);
    localparam logic [IX_W-1:0] IP_FIRST_IX = IX_W'(26);
    localparam logic [IX_W-1:0] IP_LAST_IX = IX_W'(29);
    localparam logic [15:0]     ETYPE_IPV4 = 16'h0800;

    typedef enum logic [1:0] {IDLE, HDR, BODY, DISCARD} state_t;

    state_t          state, state_next;
    logic [IX_W-1:0] idx, idx_next;
    logic [7:0]      eth_hi;
    logic [23:0]     ip_hi;
    logic            deny_q, non_ip_q;
    logic [31:0]     rule_ip [NUM_RULES];
    logic [NUM_RULES-1:0] rule_en;

    logic accept, fwd, force_end, frame_end;
    logic match, deny_now, non_ip_now, runt, invalid;

    // Ready is combinational on the FIFO almost-full; the discard state drains regardless.
    assign o_rxd_tready = rst & ((state == DISCARD) | ~i_fifo_full);

    // Parallel source-IP compare against the table as it stands this cycle.
    always_comb begin
        match = 1'b0;
        for (int r = 0; r < int'(NUM_RULES); r++) begin
            if (rule_en[r] && (rule_ip[r] == {ip_hi, i_rxd_tdata})) begin
                match = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        accept     = i_rxd_tvalid & o_rxd_tready;
        fwd        = accept & (state != DISCARD);
        force_end  = fwd & ~i_rx_tlast & (idx == LAST_IX);
        frame_end  = fwd & (i_rx_tlast | force_end);
        deny_now   = (idx == IP_LAST_IX) ? match : deny_q;
        non_ip_now = (idx == ETH_LO_IX) ? ({eth_hi, i_rxd_tdata} != ETYPE_IPV4) : non_ip_q;
        runt       = i_rx_tlast & (idx < IP_LAST_IX);
        invalid    = deny_now | runt | ((DROP_NON_IP != 0) & non_ip_now) | force_end;

        case (state)
            DISCARD: begin
                if (accept && i_rx_tlast) begin
                    state_next = IDLE;
                end
            end
            default: begin
                if (fwd) begin
                    if (i_rx_tlast) begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end else if (force_end) begin
                        state_next = DISCARD;
                        idx_next   = '0;
                    end else begin
                        state_next = (idx >= IP_LAST_IX) ? BODY : HDR;
                        idx_next   = idx + IX_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Forwarding registers, header capture, sticky flags and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_fifo_tdata   <= '0;
            o_fifo_tvalid  <= 1'b0;
            o_fifo_tlast   <= 1'b0;
            o_fifo_invalid <= 1'b0;
            eth_hi         <= '0;
            ip_hi          <= '0;
            deny_q         <= 1'b0;
            non_ip_q       <= 1'b0;
            o_pass_cnt     <= '0;
            o_drop_cnt     <= '0;
        end else begin
            o_fifo_tvalid  <= fwd;
            o_fifo_tlast   <= frame_end;
            o_fifo_invalid <= frame_end & invalid;
            if (fwd) begin
                o_fifo_tdata <= i_rxd_tdata;
                if (idx == ETH_HI_IX) begin
                    eth_hi <= i_rxd_tdata;
                end
                if ((idx >= IP_FIRST_IX) && (idx < IP_LAST_IX)) begin
                    ip_hi <= {ip_hi[15:0], i_rxd_tdata};
                end
                deny_q   <= frame_end ? 1'b0 : deny_now;
                non_ip_q <= frame_end ? 1'b0 : non_ip_now;
            end
            if (frame_end) begin
                if (invalid) begin
                    if (o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
                end else begin
                    if (o_pass_cnt != 16'hFFFF) o_pass_cnt <= o_pass_cnt + 16'd1;
                end
            end
        end
    end

    // Rule table; out-of-range indices are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rule_en <= '0;
            for (int r = 0; r < int'(NUM_RULES); r++) begin
                rule_ip[r] <= '0;
            end
        end else if (i_rule_wr_en && (32'(i_rule_idx) < NUM_RULES)) begin
            rule_ip[i_rule_idx] <= i_rule_ip;
            rule_en[i_rule_idx] <= i_rule_en;
        end
    end

endmodule

// File: tb/tb_acl_ingress_filter.sv
// Randomized bench for acl_ingress_filter against a frame-level reference model.
module tb_acl_ingress_filter;

    localparam int MAXL = 64;
    localparam int NR   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  i_rxd_tdata = '0;
    logic        i_rxd_tvalid = 1'b0;
    logic        i_rx_tlast = 1'b0;
    logic        o_rxd_tready;
    logic [7:0]  o_fifo_tdata;
    logic        o_fifo_tvalid;
    logic        o_fifo_tlast;
    logic        o_fifo_invalid;
    logic        i_fifo_full = 1'b0;
    logic        i_rule_wr_en = 1'b0;
    logic [1:0]  i_rule_idx = '0;
    logic [31:0] i_rule_ip = '0;
    logic        i_rule_en = 1'b0;
    logic [15:0] o_pass_cnt;
    logic [15:0] o_drop_cnt;

    acl_ingress_filter #(.NUM_RULES(NR), .MAX_LEN(MAXL), .DROP_NON_IP(1)) dut (
        .clk(clk), .rst(rst),
        .i_rxd_tdata(i_rxd_tdata), .i_rxd_tvalid(i_rxd_tvalid), .i_rx_tlast(i_rx_tlast),
        .o_rxd_tready(o_rxd_tready),
        .o_fifo_tdata(o_fifo_tdata), .o_fifo_tvalid(o_fifo_tvalid),
        .o_fifo_tlast(o_fifo_tlast), .o_fifo_invalid(o_fifo_invalid),
        .i_fifo_full(i_fifo_full),
        .i_rule_wr_en(i_rule_wr_en), .i_rule_idx(i_rule_idx),
        .i_rule_ip(i_rule_ip), .i_rule_en(i_rule_en),
        .o_pass_cnt(o_pass_cnt), .o_drop_cnt(o_drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference state: rule table and expected counters.
    logic [31:0] m_ip [NR];
    bit          m_en [NR];
    int          exp_pass = 0;
    int          exp_drop = 0;

    // Pending mid-frame rule write.
    logic [1:0]  pw_idx = '0;
    logic [31:0] pw_ip = '0;
    bit          pw_en = 1'b0;

    logic [31:0] ip_pool [4] = '{32'h0A000001, 32'hC0A80105, 32'hAC100002, 32'h08080808};

    logic [7:0] act_d [$];
    bit         act_l [$];
    bit         act_i [$];
    int         act_c [$];
    int         acc_c [$];

    always @(negedge clk) begin
        if (rst && o_fifo_tvalid === 1'b1) begin
            act_d.push_back(o_fifo_tdata);
            act_l.push_back(o_fifo_tlast);
            act_i.push_back(o_fifo_invalid);
            act_c.push_back(cyc);
        end
    end

    function automatic bit model_invalid(int len, logic [15:0] et, logic [31:0] ip);
        bit deny = 1'b0;
        for (int r = 0; r < NR; r++) if (m_en[r] && m_ip[r] == ip) deny = 1'b1;
        return (len > MAXL) || (len < 30) || (et != 16'h0800) || deny;
    endfunction

    task automatic write_rule(input int idx, input logic [31:0] ip, input bit en);
        @(negedge clk);
        i_rule_wr_en = 1'b1; i_rule_idx = 2'(idx); i_rule_ip = ip; i_rule_en = en;
        @(negedge clk);
        i_rule_wr_en = 1'b0;
        m_ip[idx] = ip; m_en[idx] = en;
    endtask

    // Send one frame (optional stall / same-cycle rule write) and check it against the model.
    task automatic test_frame(input string name, input int len, input logic [15:0] et,
                              input logic [31:0] ip, input int stall_at, input int wr_at);
        logic [7:0] fr [];
        int  fwd, i, t, stall_left;
        bit  inv, acc, stall_done, wr_done;
        fr = new[len];
        for (int k = 0; k < len; k++) fr[k] = 8'($urandom);
        if (len > 13) begin fr[12] = et[15:8]; fr[13] = et[7:0]; end
        if (len > 29) begin fr[26] = ip[31:24]; fr[27] = ip[23:16]; fr[28] = ip[15:8]; fr[29] = ip[7:0]; end
        fwd = (len > MAXL) ? MAXL : len;
        inv = model_invalid(len, et, ip);
        if (inv) exp_drop++; else exp_pass++;
        act_d.delete(); act_l.delete(); act_i.delete(); act_c.delete(); acc_c.delete();
        i = 0; t = 0; stall_left = 0; stall_done = 0; wr_done = 0;
        while (i < len && t < 5000) begin
            @(negedge clk);
            t++;
            i_rule_wr_en = 1'b0;
            if (i == stall_at && !stall_done) begin stall_done = 1; stall_left = 5; end
            i_fifo_full  = (stall_left > 0);
            i_rxd_tvalid = (stall_left > 0 || i == wr_at) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (i == wr_at && !wr_done) begin
                wr_done = 1;
                i_rule_wr_en = 1'b1; i_rule_idx = pw_idx; i_rule_ip = pw_ip; i_rule_en = pw_en;
            end
            i_rxd_tdata = fr[i];
            i_rx_tlast  = (i == len - 1);
            #1;
            if (stall_left > 0) begin
                checks++;
                if (o_rxd_tready !== 1'b0)
                    $display("FAIL %s stall_ready: got %b, expected 0", name, o_rxd_tready);
                stall_left--;
            end
            acc = i_rxd_tvalid && o_rxd_tready;
            if (acc && i < fwd) acc_c.push_back(cyc);
            if (acc) i++;
        end
        @(negedge clk);
        i_rxd_tvalid = 1'b0; i_rx_tlast = 1'b0; i_rule_wr_en = 1'b0; i_fifo_full = 1'b0;
        if (t >= 5000) begin
            failures++;
            $display("FAIL %s timeout: only %0d of %0d bytes accepted", name, i, len);
        end
        if (wr_at >= 0) begin m_ip[pw_idx] = pw_ip; m_en[pw_idx] = pw_en; end
        repeat (3) @(negedge clk);
        checks++;
        if (act_d.size() != fwd) begin
            failures++;
            $display("FAIL %s beat_count: got %0d, expected %0d", name, act_d.size(), fwd);
        end
        for (int k = 0; k < fwd && k < act_d.size(); k++) begin
            checks++;
            if (act_d[k] !== fr[k] || act_l[k] !== (k == fwd - 1) || k >= acc_c.size()
                || act_c[k] != acc_c[k] + 1) begin
                failures++;
                $display("FAIL %s beat%0d: got data=%h last=%b, expected data=%h last=%b (or latency not 1)",
                         name, k, act_d[k], act_l[k], fr[k], (k == fwd - 1));
            end
        end
        if (act_d.size() == fwd && fwd > 0) begin
            checks++;
            if (act_i[fwd - 1] !== inv) begin
                failures++;
                $display("FAIL %s invalid: got %b, expected %b", name, act_i[fwd - 1], inv);
            end
        end
        checks++;
        if (o_pass_cnt !== 16'(exp_pass) || o_drop_cnt !== 16'(exp_drop)) begin
            failures++;
            $display("FAIL %s counters: got pass=%0d drop=%0d, expected pass=%0d drop=%0d",
                     name, o_pass_cnt, o_drop_cnt, exp_pass, exp_drop);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        i_rxd_tvalid = 1'b1;
        #1;
        checks++;
        if (o_rxd_tready !== 1'b0 || o_fifo_tvalid !== 1'b0 || o_fifo_tlast !== 1'b0 ||
            o_fifo_invalid !== 1'b0 || o_fifo_tdata !== 8'h00 ||
            o_pass_cnt !== 16'h0 || o_drop_cnt !== 16'h0) begin
            failures++;
            $display("FAIL reset_state: got rdy=%b v=%b l=%b inv=%b d=%h pass=%0d drop=%0d, expected all 0",
                     o_rxd_tready, o_fifo_tvalid, o_fifo_tlast, o_fifo_invalid, o_fifo_tdata,
                     o_pass_cnt, o_drop_cnt);
        end
        repeat (3) @(negedge clk);
        i_rxd_tvalid = 1'b0;
        for (int r = 0; r < NR; r++) begin m_ip[r] = '0; m_en[r] = 1'b0; end
        exp_pass = 0; exp_drop = 0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (o_rxd_tready !== 1'b1 || o_fifo_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got rdy=%b v=%b, expected rdy=1 v=0", o_rxd_tready, o_fifo_tvalid);
        end
    endtask

    task automatic test_deny_rule();
        write_rule(2, 32'h0A000001, 1'b1);
        test_frame("deny_match", 64, 16'h0800, 32'h0A000001, -1, -1);
        pw_idx = 2'd2; pw_ip = 32'h0A000001; pw_en = 1'b0;
        test_frame("deny_same_cycle_write", 64, 16'h0800, 32'h0A000001, -1, 29);
        test_frame("deny_disabled", 64, 16'h0800, 32'h0A000001, -1, -1);
    endtask

    task automatic test_runt_non_ip();
        test_frame("runt_20", 20, 16'h0800, 32'h0A000001, -1, -1);
        test_frame("runt_1", 1, 16'h0800, 32'h0A000001, -1, -1);
        test_frame("runt_29", 29, 16'h0800, 32'h0A000001, -1, -1);
        test_frame("min_30", 30, 16'h0800, 32'h0A000001, -1, -1);
        test_frame("non_ip", 64, 16'h86DD, 32'h0A000001, -1, -1);
    endtask

    task automatic test_oversize();
        test_frame("oversize_100", 100, 16'h0800, 32'h0A000001, -1, -1);
        test_frame("oversize_65", 65, 16'h0800, 32'h0A000001, -1, -1);
        test_frame("after_oversize", 64, 16'h0800, 32'h0A000001, -1, -1);
    endtask

    task automatic test_backpressure();
        test_frame("stall_hdr", 64, 16'h0800, 32'hC0A80105, 15, -1);
        test_frame("stall_body", 50, 16'h0800, 32'hC0A80105, 40, -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            int len, pick;
            logic [15:0] et;
            if ($urandom_range(0, 3) == 0)
                write_rule($urandom_range(0, NR - 1), ip_pool[$urandom_range(0, 3)], 1'($urandom_range(0, 1)));
            len  = $urandom_range(1, 100);
            pick = $urandom_range(0, 9);
            et   = (pick < 7) ? 16'h0800 : 16'($urandom);
            test_frame("random", len, et, ip_pool[$urandom_range(0, 3)],
                       ($urandom_range(0, 2) == 0) ? $urandom_range(0, 60) : -1, -1);
        end
    endtask

    task automatic test_reset_midframe();
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            i_rxd_tvalid = 1'b1; i_rxd_tdata = 8'($urandom); i_rx_tlast = 1'b0;
            if (k == 12) i_rxd_tdata = 8'h08;
            if (k == 13) i_rxd_tdata = 8'h00;
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (o_rxd_tready !== 1'b0 || o_fifo_tvalid !== 1'b0 || o_fifo_tlast !== 1'b0 ||
            o_fifo_invalid !== 1'b0 || o_fifo_tdata !== 8'h00 ||
            o_pass_cnt !== 16'h0 || o_drop_cnt !== 16'h0) begin
            failures++;
            $display("FAIL midframe_reset: got rdy=%b v=%b l=%b inv=%b d=%h pass=%0d drop=%0d, expected all 0",
                     o_rxd_tready, o_fifo_tvalid, o_fifo_tlast, o_fifo_invalid, o_fifo_tdata,
                     o_pass_cnt, o_drop_cnt);
        end
        @(negedge clk);
        i_rxd_tvalid = 1'b0;
        for (int r = 0; r < NR; r++) begin m_ip[r] = '0; m_en[r] = 1'b0; end
        exp_pass = 0; exp_drop = 0;
        @(negedge clk);
        rst = 1'b1;
        test_frame("after_reset", 64, 16'h0800, 32'h0A000001, -1, -1);
    endtask

    initial begin
        test_reset();
        test_frame("ipv4_pass", 64, 16'h0800, 32'h0A000001, -1, -1);
        test_deny_rule();
        test_runt_non_ip();
        test_oversize();
        test_backpressure();
        test_random();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
